id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Clock/reset: i_clk rising-edge; reset i_rst, asynchronous, active-low.
REQ-002 i_clk  in  1  core clock.
REQ-003 i_rst  in  1  async active-low reset.
REQ-004 i_instr_valid  in  1  fetch offers instruction.
REQ-005 i_instr  in  32  RV32I instruction word.
REQ-006 i_pc  in  32  PC of offered instruction.
REQ-007 o_instr_ready  out  1  stage accepts offered instruction.
REQ-008 o_rs1, o_rs2  out  5 each  register-file read addresses.
REQ-009 i_rs1_val, i_rs2_val  in  32 each  register-file read data (combinational, same cycle).
REQ-010 i_wb_en  in  1, i_wb_rd  in  5, i_wb_val  in  32  writeback port, same values driven to register-file write port.
REQ-011 i_flush  in  1  discard held and offered instruction.
REQ-012 o_valid  out  1  decoded bundle valid; i_ready  in  1  execute accepts bundle.
REQ-013 o_pc 32, o_op_a 32, o_op_b 32, o_imm 32, o_rd 5, o_rd_we 1, o_opcode 7, o_funct3 3, o_funct7b5 1, o_illegal 1  all out, registered bundle fields.

Function
REQ-014 o_rs1 = i_instr[19:15], o_rs2 = i_instr[24:20], combinational, every cycle regardless of valid.
REQ-015 o_instr_ready = !o_valid || i_ready (single-entry pipeline register, no bubble on continuous flow).
REQ-016 Capture on edge when i_instr_valid && o_instr_ready && !i_flush; o_valid <= 1 next cycle; latency 1 cycle.
REQ-017 o_valid <= 0 on edge when i_ready && o_valid and no capture; i_flush forces o_valid <= 0 and blocks capture that edge.
REQ-018 Operand forwarding: if i_wb_en && i_wb_rd != 0 && i_wb_rd == rsN then captured operand = i_wb_val, else i_rsN_val.
REQ-019 rsN == 0 always captures 0 irrespective of inputs.
REQ-020 Stall refresh: while o_valid && !i_ready, if i_wb_en && i_wb_rd != 0 matches held rs1/rs2 index, corresponding held operand <= i_wb_val; all other bundle fields held stable.
REQ-021 Held rs1/rs2 indices stored internally for REQ-020.
REQ-022 Immediate, sign-extended to 32: I (0010011, 0000011, 1100111) instr[31:20]; S (0100011) {instr[31:25],instr[11:7]}; B (1100011) {instr[31],instr[7],instr[30:25],instr[11:8],0}; U (0110111, 0010111) {instr[31:12],12'b0}; J (1101111) {instr[31],instr[19:12],instr[20],instr[30:21],0}; R (0110011) 0.
REQ-023 o_rd = instr[11:7]; o_rd_we = 1 only for R, I, U, J opcodes and rd != 0; 0 for S, B, illegal.
REQ-024 o_opcode/o_funct3/o_funct7b5 = instr[6:0]/[14:12]/[30].
REQ-025 o_illegal = 1 when opcode not in set of REQ-022 or instr[1:0] != 2'b11; illegal bundle still issued, o_rd_we = 0, o_imm = 0.
REQ-026 Simultaneous flush and i_ready: flush wins, no capture.

Reset
REQ-027 i_rst low: o_valid = 0 immediately; all registered bundle fields and held indices = 0; o_instr_ready = 1 during reset follows REQ-015.
REQ-028 Reset mid-stall discards held bundle; no output valid until new capture after reset release.

Verification
REQ-029 Reset then addi x5,x0,7 (0x00700293), pc 0x100, i_ready=1 -> next cycle o_valid=1, o_imm=7, o_rd=5, o_rd_we=1, o_op_a=0.
REQ-030 add x3,x1,x2 with i_rs1_val=0x10, i_rs2_val=0x20, same cycle i_wb_en=1, i_wb_rd=1, i_wb_val=0x55 -> o_op_a=0x55, o_op_b=0x20.
REQ-031 Hold i_ready=0 with bundle rs2=2, pulse writeback rd=2 val 0xDEAD -> o_op_b=0xDEAD next cycle, o_pc/o_imm unchanged, o_instr_ready=0.
REQ-032 sw x2,-4(x1) (0xFE20AE23) -> o_imm=0xFFFFFFFC, o_rd_we=0; beq offset -8 -> o_imm=0xFFFFFFF8.
REQ-033 Back-to-back 4 instructions with i_ready=1 -> 4 consecutive o_valid cycles, no bubbles; i_flush with valid input -> o_valid=0 next cycle.
REQ-034 Word 0xFFFFFFFF -> o_illegal=1, o_rd_we=0; writeback to x0 with rs1=0 -> o_op_a=0.

Source files
------------

// File: rtl/id_stage_if.sv
// id_stage_if: fetch -> decode instruction handshake.
//   instr_valid : fetch offers an instruction
//   instr       : RV32I instruction word
//   pc          : PC of the offered instruction
//   instr_ready : decode stage accepts the offered instruction
// master = fetch side, slave = decode stage.
interface id_stage_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;

    modport master (output instr_valid, instr, pc, input instr_ready);
    modport slave  (input instr_valid, instr, pc, output instr_ready);
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a single-entry output register.
//   i_clk, i_rst         : clock, asynchronous active-low reset
//   fetch                : instruction handshake (id_stage_if.slave)
//   o_rs1, o_rs2         : register-file read addresses (combinational)
//   i_rs1_val, i_rs2_val : register-file read data (same cycle)
//   i_wb_en/_rd/_val     : writeback port, used for operand forwarding
//   i_flush              : discard held and offered instruction
//   o_valid, i_ready     : decoded bundle handshake to execute
//   o_pc .. o_illegal    : registered decoded bundle
module id_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    id_stage_if.slave   fetch,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_val,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_op_a,
    output logic [31:0] o_op_b,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic        o_rd_we,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic        o_funct7b5,
    output logic        o_illegal
);

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_JALR   = 7'b1100111,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_OP     = 7'b0110011
    } opcode_e;

    logic [31:0] instr;
    logic        capture;
    logic [31:0] dec_imm;
    logic        dec_legal;
    logic        dec_writes;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;

    assign instr = fetch.instr;
    assign o_rs1 = instr[19:15];
    assign o_rs2 = instr[24:20];

    assign fetch.instr_ready = !o_valid || i_ready;
    assign capture = fetch.instr_valid && fetch.instr_ready && !i_flush;

    always_comb begin
        dec_imm    = '0;
        dec_legal  = 1'b0;
        dec_writes = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_imm    = {{20{instr[31]}}, instr[31:20]};
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_STORE: begin
                dec_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_legal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_legal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm    = {instr[31:12], 12'b0};
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_JAL: begin
                dec_imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            OPC_OP: begin
                dec_legal  = 1'b1;
                dec_writes = 1'b1;
            end
            default: ;
        endcase
        if (instr[1:0] != 2'b11) begin
            dec_legal  = 1'b0;
            dec_writes = 1'b0;
            dec_imm    = '0;
        end
    end

    // x0 reads as zero; a non-zero index matching the writeback takes the
    // in-flight value (wb_rd != 0 is implied by the index being non-zero).
    always_comb begin
        fwd_a = i_rs1_val;
        fwd_b = i_rs2_val;
        if (o_rs1 == '0) begin
            fwd_a = '0;
        end else if (i_wb_en && (i_wb_rd == o_rs1)) begin
            fwd_a = i_wb_val;
        end
        if (o_rs2 == '0) begin
            fwd_b = '0;
        end else if (i_wb_en && (i_wb_rd == o_rs2)) begin
            fwd_b = i_wb_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_op_a     <= '0;
            o_op_b     <= '0;
            o_imm      <= '0;
            o_rd       <= '0;
            o_rd_we    <= 1'b0;
            o_opcode   <= '0;
            o_funct3   <= '0;
            o_funct7b5 <= 1'b0;
            o_illegal  <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (capture) begin
            o_valid    <= 1'b1;
            o_pc       <= fetch.pc;
            o_op_a     <= fwd_a;
            o_op_b     <= fwd_b;
            o_imm      <= dec_imm;
            o_rd       <= instr[11:7];
            o_rd_we    <= dec_writes && (instr[11:7] != '0);
            o_opcode   <= instr[6:0];
            o_funct3   <= instr[14:12];
            o_funct7b5 <= instr[30];
            o_illegal  <= !dec_legal;
            rs1_q      <= o_rs1;
            rs2_q      <= o_rs2;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else if (o_valid) begin
            // Stalled: keep held operands coherent with writebacks that
            // land while execute is not accepting.
            if (i_wb_en && (i_wb_rd != '0) && (i_wb_rd == rs1_q)) begin
                o_op_a <= i_wb_val;
            end
            if (i_wb_en && (i_wb_rd != '0) && (i_wb_rd == rs2_q)) begin
                o_op_b <= i_wb_val;
            end
        end
    end

endmodule
